// File: rtl/inner_loop_param_if.sv
// Start handshake and carry-save result bus of the parametrised inner-loop row multiplier.
// Handshake: a job is accepted on a rising clk edge where start_valid && start_ready; a/bi matter only at that edge.
interface inner_loop_param_if #(
    parameter int SIZE  = 3072,
    parameter int RADIX = 54
);
    localparam int OW = SIZE + RADIX + 2;

    logic              start_valid;
    logic              start_ready;
    logic [SIZE+1:0]   a;
    logic [RADIX-1:0]  bi;
    logic [OW-1:0]     r0;
    logic [OW-1:0]     r1;
    logic              busy;
    logic              done;

    modport master (
        output start_valid, a, bi,
        input  start_ready, r0, r1, busy, done
    );

    modport slave (
        input  start_valid, a, bi,
        output start_ready, r0, r1, busy, done
    );
endinterface

// File: rtl/inner_loop_param.sv
// Inner-loop row multiplier: a*bi for one radix digit, LANES digit multipliers time-shared over P passes.
// Result is carry-save: digit k low half lands in r0 digit k, high half in r1 digit k+1.
module inner_loop_param #(
    parameter int SIZE    = 3072,
    parameter int RADIX   = 54,
    parameter int LANES   = 19,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    inner_loop_param_if.slave bus,
    output logic [1:0]        dbg_state
);
    localparam int AW = SIZE + 2;
    localparam int D  = (AW + RADIX - 1) / RADIX;
    localparam int P  = (D + LANES - 1) / LANES;
    localparam int OW = SIZE + RADIX + 2;
    localparam int EW = P * LANES * RADIX;
    localparam int RW = (D + 1) * RADIX;
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [PW-1:0]                  pass_q, pass_d;
    logic                           accept;
    logic                           issue;

    logic [EW-1:0]                  a_sh;
    logic [RADIX-1:0]               bi_q;

    logic [LANES-1:0][RADIX-1:0]    op_a;
    logic [LANES-1:0]               op_v;
    logic [PW-1:0]                  op_pass;
    logic                           op_last;

    logic [LANES-1:0][2*RADIX-1:0]  lane_prod;
    logic [LANES-1:0][2*RADIX-1:0]  wr_prod;
    logic [LANES-1:0]               wr_v;
    logic [PW-1:0]                  wr_pass;
    logic                           wr_last;

    logic [OW-1:0]                  r0_q, r0_d;
    logic [OW-1:0]                  r1_q, r1_d;
    logic                           done_q;
    logic                           busy_q;

    // DRAIN ends on the edge that writes the last pass, so IDLE and done coincide with that write.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        issue   = 1'b0;
        accept  = bus.start_valid && (state_q == IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    pass_d  = '0;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (pass_q == PW'(P - 1)) begin
                    state_d = DRAIN;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end
            DRAIN: begin
                if (wr_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= '0;
            a_sh    <= '0;
            bi_q    <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            if (accept) begin
                a_sh <= EW'(bus.a);
                bi_q <= bus.bi;
            end else if (issue) begin
                a_sh <= a_sh >> (LANES * RADIX);
            end
            r0_q   <= r0_d;
            r1_q   <= r1_d;
            done_q <= wr_last;
            busy_q <= accept || (state_q != IDLE);
        end
    end

    // Each pass shifts the operand down, so lane j always reads the same low slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_v    <= '0;
            op_pass <= '0;
            op_last <= 1'b0;
        end else begin
            op_v    <= '0;
            op_last <= 1'b0;
            if (issue) begin
                for (int j = 0; j < LANES; j++) begin
                    op_a[j] <= a_sh[RADIX*j +: RADIX];
                    op_v[j] <= (int'(pass_q) * LANES + j) < D;
                end
                op_pass <= pass_q;
                op_last <= (pass_q == PW'(P - 1));
            end
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_prod[j] = (2*RADIX)'(op_a[j]) * (2*RADIX)'(bi_q);
        end
    end

    if (MUL_LAT == 1) begin : g_direct
        assign wr_prod = lane_prod;
        assign wr_v    = op_v;
        assign wr_pass = op_pass;
        assign wr_last = op_last;
    end else begin : g_pipe
        localparam int S = MUL_LAT - 1;

        logic [LANES-1:0][2*RADIX-1:0] pp [S];
        logic [LANES-1:0]              pv [S];
        logic [PW-1:0]                 pt [S];
        logic [S-1:0]                  pl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < S; s++) begin
                    pp[s] <= '0;
                    pv[s] <= '0;
                    pt[s] <= '0;
                end
                pl <= '0;
            end else begin
                pp[0] <= lane_prod;
                pv[0] <= op_v;
                pt[0] <= op_pass;
                pl[0] <= op_last;
                for (int s = 1; s < S; s++) begin
                    pp[s] <= pp[s-1];
                    pv[s] <= pv[s-1];
                    pt[s] <= pt[s-1];
                    pl[s] <= pl[s-1];
                end
            end
        end

        assign wr_prod = pp[S-1];
        assign wr_v    = pv[S-1];
        assign wr_pass = pt[S-1];
        assign wr_last = pl[S-1];
    end

    // The top r1 digit straddles bit OW; the cast to OW bits drops the part that is provably zero.
    always_comb begin
        r0_d = r0_q;
        r1_d = r1_q;
        if (accept) begin
            r0_d = '0;
            r1_d = '0;
        end else begin
            for (int k = 0; k < D; k++) begin
                if (wr_v[k % LANES] && (wr_pass == PW'(k / LANES))) begin
                    r0_d[RADIX*k +: RADIX] = wr_prod[k % LANES][RADIX-1:0];
                    r1_d = (r1_d & ~OW'(RW'({RADIX{1'b1}}) << (RADIX * (k + 1))))
                         | OW'(RW'(wr_prod[k % LANES][2*RADIX-1:RADIX]) << (RADIX * (k + 1)));
                end
            end
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.r0          = r0_q;
    assign bus.r1          = r1_q;
    assign dbg_state       = state_q;
endmodule
